// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM encoding and sizing helpers shared by the serial adder
package serial_adder_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;
  function automatic int steps(input int w, input int b);
    return w / b;
  endfunction
  function automatic int cnt_w(input int s);
    return s > 1 ? $clog2(s) : 1;
  endfunction
endpackage

// File: rtl/adder_slice.sv
// adder_slice: BPC-bit ripple of full adders (x, y, ci in; s, cout, c_msb = carry into top bit)
module adder_slice #(
  parameter int BPC = 1
) (
  input  logic [BPC-1:0] x,
  input  logic [BPC-1:0] y,
  input  logic           ci,
  output logic [BPC-1:0] s,
  output logic           cout,
  output logic           c_msb
);
  logic [BPC:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < BPC; i++) begin : g_fa
    full_adder u_fa (.x(x[i]), .y(y[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  assign cout  = c[BPC];
  assign c_msb = c[BPC-1];
endmodule

// File: rtl/full_adder.sv
// full_adder: one-bit full adder (x, y, ci in; s, co out)
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/sub, BPC bits per clock LSB first
//   in : clk, rst (async high), start, sub, a, b, cin
//   out: busy, done (1-cycle pulse), sum, cout (sub: 1 = no borrow), overflow
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int STEPS = steps(WIDTH, BPC);
  localparam int SW    = cnt_w(STEPS);
  if (WIDTH % BPC != 0) begin : g_bad_bpc
    $error("serial_adder: WIDTH must be a multiple of BPC");
  end
  state_t           state;
  logic [SW-1:0]    step;
  logic [WIDTH-1:0] ar, br, sr, nxt;
  logic             carry, last, sc, sm;
  logic [BPC-1:0]   ss;
  adder_slice #(.BPC(BPC)) u_slice (
    .x(ar[BPC-1:0]), .y(br[BPC-1:0]), .ci(carry), .s(ss), .cout(sc), .c_msb(sm)
  );
  // slice result enters at the MSB end so the LSB slice lands at bit 0 after STEPS shifts
  assign nxt  = (sr >> BPC) | (WIDTH'(ss) << (WIDTH - BPC));
  assign last = step == SW'(STEPS - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      step     <= '0;
      ar       <= '0;
      br       <= '0;
      sr       <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (state != RUN) begin
      state <= start ? RUN : IDLE;
      if (start) begin
        ar    <= a;
        br    <= sub ? ~b : b;
        carry <= cin ^ sub;
        step  <= '0;
      end
    end else begin
      ar    <= ar >> BPC;
      br    <= br >> BPC;
      sr    <= nxt;
      carry <= sc;
      step  <= last ? step : step + 1'b1;
      if (last) begin
        state    <= DONE;
        sum      <= nxt;
        cout     <= sc;
        overflow <= sm ^ sc;
      end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven and randomised scoreboard checks of serial_adder
module tb_serial_adder;
  typedef struct packed {
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;
  localparam int NR = 4;
  localparam int CW [NR] = '{16, 16, 16, 8};
  localparam int CB [NR] = '{1, 2, 4, 2};
  logic clk = 1'b0, rst = 1'b1, go = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0, nfin = 0;
  logic start1 = 1'b0, start4 = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0, s1, s4;
  logic busy1, done1, co1, ov1, busy4, done4, co4, ov4;
  logic [9:0] q1 [$], q4 [$];
  serial_adder #(.WIDTH(8), .BPC(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy1), .done(done1), .sum(s1), .cout(co1), .overflow(ov1)
  );
  serial_adder #(.WIDTH(8), .BPC(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy4), .done(done4), .sum(s4), .cout(co4), .overflow(ov4)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst && done1) begin
    if (q1.size() == 0) chk("u1 spurious done", 1, 0);
    else chk("u1 result {cout,ov,sum}", {co1, ov1, s1}, q1.pop_front());
  end
  always @(negedge clk) if (!rst && done4) begin
    if (q4.size() == 0) chk("u4 spurious done", 1, 0);
    else chk("u4 result {cout,ov,sum}", {co4, ov4, s4}, q4.pop_front());
  end
  task automatic run(input vec_t v);
    int n1 = 0, n4 = 0, cyc = 0, bc = 0;
    sub = v.sub; cin = v.cin; a = v.a; b = v.b;
    start1 = 1'b1; start4 = 1'b1;
    q1.push_back({v.co, v.ov, v.s});
    q4.push_back({v.co, v.ov, v.s});
    @(posedge clk); #1 start1 = 1'b0; start4 = 1'b0; cyc = 1;
    while ((n1 == 0 || n4 == 0) && cyc < 40) begin
      if (busy1) bc++;
      @(posedge clk); #1 cyc++;
      if (done1 && n1 == 0) n1 = cyc;
      if (done4 && n4 == 0) n4 = cyc;
    end
    chk("latency BPC=1", n1, 9);
    chk("latency BPC=4", n4, 3);
    chk("busy cycles BPC=1", bc, 8);
  endtask
  initial begin
    vec_t tv [8];
    int n;
    tv[0] = '{1'b0, 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1};
    tv[1] = '{1'b0, 1'b1, 8'hFF, 8'h01, 8'h01, 1'b1, 1'b0};
    tv[2] = '{1'b1, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
    tv[3] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    tv[4] = '{1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    tv[5] = '{1'b1, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};
    tv[6] = '{1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
    tv[7] = '{1'b1, 1'b0, 8'h55, 8'h55, 8'h00, 1'b1, 1'b0};
    repeat (2) @(posedge clk);
    #1 chk("reset busy/done", {busy1, busy4, done1, done4}, 0);
    chk("reset sum", {s1, s4}, 0);
    chk("reset cout/ov", {co1, ov1, co4, ov4}, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) run(tv[i]);
    // start held high through the whole op: only the DONE-cycle start is taken
    sub = 1'b0; cin = 1'b0; a = 8'h5A; b = 8'h3C; start1 = 1'b1;
    q1.push_back({1'b0, 1'b1, 8'h96});
    @(posedge clk); #1 a = 8'h11; b = 8'h22;
    q1.push_back({1'b0, 1'b0, 8'h33});
    n = 0;
    for (int i = 2; i <= 12 && n == 0; i++) begin
      @(posedge clk); #1 if (done1) n = i;
    end
    chk("held start first done", n, 9);
    @(posedge clk); #1 chk("back-to-back busy", {busy1, done1}, 2'b10);
    start1 = 1'b0;
    n = 0;
    for (int i = 2; i <= 14 && n == 0; i++) begin
      @(posedge clk); #1 if (done1) n = i;
    end
    chk("back-to-back second done", n, 9);
    // abort at step 3 with a reset pulse
    a = 8'hFF; b = 8'hFF; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("busy before abort", busy1, 1);
    rst = 1'b1;
    #1 chk("abort outputs", {busy1, done1, co1, ov1, s1}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1 if (done1 || busy1) n++;
    end
    chk("idle after abort", n, 0);
    run(tv[0]);
    run(tv[2]);
    go = 1'b1;
    for (int t = 0; t < 20000 && nfin < NR; t++) @(posedge clk);
    chk("random phase complete", nfin, NR);
    repeat (2) @(posedge clk);
    chk("directed queues drained", q1.size() + q4.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  for (genvar g = 0; g < NR; g++) begin : rnd
    localparam int W = CW[g];
    localparam int B = CB[g];
    logic st = 1'b0, sb = 1'b0, ci = 1'b0, rbusy, rdone, rco, rov;
    logic [W-1:0] ra = '0, rb = '0, rs;
    logic [W+1:0] q [$];
    serial_adder #(.WIDTH(W), .BPC(B)) u (
      .clk(clk), .rst(rst), .start(st), .sub(sb), .a(ra), .b(rb), .cin(ci),
      .busy(rbusy), .done(rdone), .sum(rs), .cout(rco), .overflow(rov)
    );
    always @(negedge clk) if (!rst && rdone) begin
      if (q.size() == 0) chk($sformatf("rnd W%0d B%0d spurious done", W, B), 1, 0);
      else chk($sformatf("rnd W%0d B%0d {cout,ov,sum}", W, B), 32'({rco, rov, rs}), 32'(q.pop_front()));
    end
    initial begin
      logic [W-1:0] bb;
      logic [W:0] ext;
      int t;
      wait (go);
      for (int i = 0; i < 250; i++) begin
        ra = W'($urandom); rb = W'($urandom); sb = 1'($urandom); ci = 1'($urandom);
        bb = sb ? ~rb : rb;
        ext = {1'b0, ra} + {1'b0, bb} + (W+1)'(ci ^ sb);
        q.push_back({ext[W], (ra[W-1] == bb[W-1]) && (ext[W-1] != ra[W-1]), ext[W-1:0]});
        st = 1'b1;
        @(posedge clk); #1 st = 1'b0;
        t = 0;
        while (!rdone && t < W + 4) begin
          @(posedge clk); #1 t++;
        end
        if (!rdone) chk($sformatf("rnd W%0d B%0d done timeout", W, B), 1, 0);
      end
      @(posedge clk);
      nfin++;
    end
  end
endmodule
